stochastic_result_uart_tx: RTL and testbench
============================================

Name: stochastic_result_uart_tx

Overview:
UART transmit side of the stochastic REPL core. It replaces the constant-high uart_tx tie-off.
On each accepted result from the bitstream-to-binary converter, it serialises a fixed 7-byte ASCII message, "R" + 4 uppercase hex digits + CR + LF, as 8N1 frames.
It sits between the converter output (result_binary / conversion_done) and the top-level uart_tx pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range is >= 2; the baud counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
clk  input  1  system clock; single clock domain, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
result_value  input  16  binary result to report; sampled only on acceptance
result_valid  input  1  single-cycle strobe; result offered this cycle (driven by conversion_done)
result_ready  output  1  registered; high when idle and able to accept
overrun_clr  input  1  synchronous clear of overrun
uart_tx  output  1  serial line; idle high
busy  output  1  registered; high from acceptance until the last stop bit ends
overrun  output  1  sticky; set when result_valid arrives while result_ready=0

Behaviour:
- Reset values (applied immediately on rst rising, asynchronous):
  - uart_tx=1, result_ready=1, busy=0, overrun=0
  - FSM=IDLE, all counters 0
- Acceptance:
  - Occurs when result_valid && result_ready at a clock edge.
  - result_value is latched into a 16-bit holding register.
  - result_ready goes 0 and busy goes 1 on the same edge.
- FSM states: IDLE -> START -> DATA -> STOP -> (START for the next byte | IDLE).
  - IDLE: uart_tx=1. On acceptance, go to START with byte_idx=0.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit_idx runs 0..7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<6: increment byte_idx, go to START. There is no inter-byte idle gap.
    - If byte_idx==6: go to IDLE; result_ready=1 and busy=0 on that same edge.
- Latency:
  - uart_tx falls on the edge following acceptance, i.e. it is driven from a registered output.
  - The whole message occupies exactly 70*CLKS_PER_BIT cycles; busy is high for exactly that many cycles.
- Byte sequence by byte_idx:
  - 0: 0x52 ('R')
  - 1..4: hex of nibbles [15:12], [11:8], [7:4], [3:0] respectively
  - 5: 0x0D
  - 6: 0x0A
- Hex encoding:
  - nibble n<10 -> 0x30+n
  - n>=10 -> 0x41+(n-10), uppercase
  - Computed from the holding register, never from live result_value.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - The bit/state advance happens on the wrap edge.
- Back-pressure and overrun:
  - result_valid while result_ready=0 is dropped. The in-flight message and holding register are unaffected, and overrun is set.
  - If overrun set and overrun_clr occur in the same cycle, set wins.
  - overrun_clr alone clears overrun on the next edge.
- Reset mid-message:
  - The frame is truncated and uart_tx returns high immediately.
  - The holding register is cleared to 0.
  - After rst deasserts, the next accepted result sends a complete message from byte 0.
- result_value changing during transmission has no effect.

Test Plan:
- CLKS_PER_BIT=4, result_value=0x1A2F, 1-cycle result_valid -> uart_tx carries 0x52,0x31,0x41,0x32,0x46,0x0D,0x0A in 8N1; busy high for exactly 280 cycles; result_ready=1 on the cycle busy falls.
- Bit timing on the first byte -> uart_tx low 1 cycle after acceptance, held low exactly 4 cycles; then data bits 0,1,0,0,1,0,1,0 (0x52 LSB first) at 4 cycles each; then stop high 4 cycles; the next start bit follows immediately.
- Boundary values:
  - 0x0000 -> "R0000\r\n"
  - 0xFFFF -> "RFFFF\r\n"
  - 0x9A00 -> digits 0x39,0x41,0x30,0x30 (checks the 9/A encoding boundary)
- Result 0x1234 accepted, then result_valid with 0xBEEF at cycle 50 -> 0xBEEF dropped; output stays "R1234\r\n"; overrun=1 from cycle 51.
  - overrun_clr pulsed alone -> overrun=0 next cycle.
  - overrun_clr coincident with a new dropped valid -> overrun stays 1.
- Assert rst during byte 3 of a message -> uart_tx=1, busy=0, result_ready=1 with no clock edge needed. Release rst, send 0x00FF -> complete "R00FF\r\n" with correct timing.
- Back-to-back: result_valid asserted on the exact cycle result_ready returns to 1 -> accepted; the new start bit begins the next cycle; no idle gap longer than 1 cycle between messages.

Source files
------------

// File: rtl/stochastic_result_uart_tx.sv
// Serialises each accepted 16-bit result as the ASCII message "R" + 4 hex digits + CR + LF.
// Each byte is sent as an 8N1 UART frame, with no idle gap between bytes.
`timescale 1ns/1ps
module stochastic_result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] result_value,
   input  logic        result_valid,
   output logic        result_ready,
   input  logic        overrun_clr,
   output logic        uart_tx,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_baud;
   logic [2:0]      r_bit_idx;
   logic [2:0]      r_byte_idx;
   logic [15:0]     r_hold;
   logic            r_tx;
   logic            r_ready;
   logic            r_busy;
   logic            r_overrun;

   logic [7:0]      w_byte;
   logic            w_wrap;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      // 'A' - 10 = 0x37, so letters land on uppercase A..F
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

   assign w_wrap = (r_baud == CntMax);

   // Select the byte currently being framed, always from the holding register
   always_comb begin
      w_byte = 8'hFF;
      case (r_byte_idx)
         3'd0:    w_byte = 8'h52;
         3'd1:    w_byte = hex_ascii(r_hold[15:12]);
         3'd2:    w_byte = hex_ascii(r_hold[11:8]);
         3'd3:    w_byte = hex_ascii(r_hold[7:4]);
         3'd4:    w_byte = hex_ascii(r_hold[3:0]);
         3'd5:    w_byte = 8'h0D;
         3'd6:    w_byte = 8'h0A;
         default: w_byte = 8'hFF;
      endcase
   end

   // Sticky overrun: a dropped strobe wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (result_valid && !r_ready) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

   // Transmit FSM with registered line, ready and busy outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_hold     <= '0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_tx <= 1'b1;
               if (result_valid && r_ready) begin
                  r_hold     <= result_value;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
                  r_byte_idx <= '0;
                  r_bit_idx  <= '0;
                  r_baud     <= '0;
                  r_tx       <= 1'b0;
                  r_state    <= StStart;
               end
            end
            StStart: begin
               if (w_wrap) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= w_byte[0];
                  r_state   <= StData;
               end else begin
                  r_baud <= r_baud + CntOne;
               end
            end
            StData: begin
               if (w_wrap) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= StStop;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= w_byte[r_bit_idx + 3'd1];
                  end
               end else begin
                  r_baud <= r_baud + CntOne;
               end
            end
            StStop: begin
               if (w_wrap) begin
                  r_baud <= '0;
                  if (r_byte_idx == 3'd6) begin
                     r_tx    <= 1'b1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= StIdle;
                  end else begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                     r_tx       <= 1'b0;
                     r_state    <= StStart;
                  end
               end else begin
                  r_baud <= r_baud + CntOne;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign uart_tx      = r_tx;
   assign result_ready = r_ready;
   assign busy         = r_busy;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_stochastic_result_uart_tx.sv
// Bench for stochastic_result_uart_tx: per-cycle comparison of the serial line against a
// message/frame model built from the ASCII message format.
`timescale 1ns/1ps
module tb_stochastic_result_uart_tx;

   localparam int CPB = 4;
   localparam int MsgCycles = 70 * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] result_value = '0;
   logic        result_valid = 1'b0;
   logic        result_ready;
   logic        overrun_clr = 1'b0;
   logic        uart_tx;
   logic        busy;
   logic        overrun;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [7:0]  exp_msg [7];
   logic        exp_ov  = 1'b0;

   stochastic_result_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .result_value (result_value),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overrun_clr  (overrun_clr),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) return 8'(48 + int'(n));
      else           return 8'(65 + int'(n) - 10);
   endfunction

   task automatic build_msg(input logic [15:0] v);
      exp_msg[0] = "R";
      exp_msg[1] = hex_char(v[15:12]);
      exp_msg[2] = hex_char(v[11:8]);
      exp_msg[3] = hex_char(v[7:4]);
      exp_msg[4] = hex_char(v[3:0]);
      exp_msg[5] = 8'h0D;
      exp_msg[6] = 8'h0A;
   endtask

   // Line level expected i cycles after the acceptance edge
   function automatic logic exp_tx(input int i);
      int j;
      int k;
      j = i / (10 * CPB);
      k = (i / CPB) % 10;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return exp_msg[j][k-1];
   endfunction

   task automatic check_idle_state(input string tag);
      check({tag, "_tx"}, 32'(uart_tx), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(result_ready), 32'd1);
      check({tag, "_ovr"}, 32'(overrun), 32'(exp_ov));
   endtask

   task automatic idle(input int n);
      result_valid = 1'b0;
      overrun_clr  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         check_idle_state("idle");
      end
   endtask

   // mode 0: plain message; 1: overrun/clear sequence during it; 2: reset during byte 3
   task automatic run_msg(input logic [15:0] v, input int mode);
      logic nxt_ov;
      build_msg(v);
      result_value = v;
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      for (int i = 0; i < MsgCycles; i++) begin
         check($sformatf("tx[%0d]", i), 32'(uart_tx), 32'(exp_tx(i)));
         check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
         check($sformatf("ready[%0d]", i), 32'(result_ready), 32'd0);
         check($sformatf("ovr[%0d]", i), 32'(overrun), 32'(exp_ov));
         if (mode == 2 && i == 130) begin
            rst = 1'b1;
            #1;
            exp_ov = 1'b0;
            check_idle_state("rst_mid");
            return;
         end
         result_value = 16'($urandom);
         result_valid = 1'b0;
         overrun_clr  = 1'b0;
         if (mode == 1) begin
            case (i)
               50: begin result_valid = 1'b1; result_value = 16'hBEEF; end
               60: overrun_clr = 1'b1;
               70: begin result_valid = 1'b1; overrun_clr = 1'b1; end
               80: overrun_clr = 1'b1;
               default: ;
            endcase
         end else if ($urandom_range(0, 15) == 0) begin
            overrun_clr = 1'b1;
         end
         nxt_ov = result_valid ? 1'b1 : (overrun_clr ? 1'b0 : exp_ov);
         @(posedge clk); #1;
         exp_ov = nxt_ov;
      end
      result_valid = 1'b0;
      overrun_clr  = 1'b0;
      check_idle_state("done");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_idle_state("reset");
      rst = 1'b0;
      idle(2);

      run_msg(16'h1A2F, 0);
      idle(3);
      run_msg(16'h0000, 0);
      idle(1);
      run_msg(16'hFFFF, 0);
      idle(2);
      // back-to-back: next valid offered on the cycle ready returns
      run_msg(16'h9A00, 0);
      run_msg(16'($urandom), 0);
      idle(2);
      run_msg(16'h1234, 1);
      idle(2);
      run_msg(16'($urandom), 2);
      repeat (2) begin
         @(posedge clk); #1;
         check_idle_state("in_rst");
      end
      rst = 1'b0;
      idle(2);
      run_msg(16'h00FF, 0);
      for (int n = 0; n < 5; n++) begin
         idle(int'($urandom_range(0, 4)));
         run_msg(16'($urandom), 0);
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
